// File: rtl/spi_counter_master_ctrl.sv
// spi_counter_master_ctrl
//   Master-side transaction controller for the SPI up-counter link. A 14-bit
//   up-counter advances on a prescaled tick. Every counter update (tick or
//   clear) queues a one-deep transaction. The transaction lowers SS and sends
//   {2'b00, cnt[13:8]} followed by cnt[7:0] through spi_master.
//
//   Optional build macro: SPI_CHECKSUM_EN
//     When defined, a third byte ({2'b00, hi} ^ lo) is sent before HOLD.
//     The far-end slave must be built with the same option.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   run_en       level; counter advances on ticks while high
//   clear        1-cycle pulse; counter to 0 and a transfer of 0 is queued
//   spi_done     1-cycle pulse from spi_master; current byte finished
//   spi_start    1-cycle pulse to spi_master; spi_tx_data valid in same cycle
//   spi_tx_data  byte to transmit (holds outside the send cycles)
//   ss           slave select, active-low
//   counter      live counter value
//   busy         high from leaving IDLE until return to IDLE
module spi_counter_master_ctrl #(
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned CNT_MAX  = 9999,
  parameter int unsigned SS_SETUP = 4,
  parameter int unsigned SS_HOLD  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        clear,
  input  logic        spi_done,
  output logic        spi_start,
  output logic [7:0]  spi_tx_data,
  output logic        ss,
  output logic [13:0] counter,
  output logic        busy
);

  localparam int unsigned DIV_W   = $clog2(TICK_DIV);
  localparam int unsigned TMR_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

`ifdef SPI_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, SETUP, SEND_H, WAIT_H, SEND_L, WAIT_L, SEND_C, WAIT_C, HOLD
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, SETUP, SEND_H, WAIT_H, SEND_L, WAIT_L, HOLD
  } state_t;
`endif

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   div_nxt;
  logic [TMR_W-1:0]   timer;
  logic [13:0]        shadow;
  logic [13:0]        cnt_nxt;
  logic               pending;
  logic               tick;
  logic               upd;

  // Next counter/divider values; clear wins over a coincident tick.
  always_comb begin
    tick    = run_en && (div == DIV_W'(TICK_DIV - 1));
    upd     = clear || tick;
    div_nxt = '0;
    cnt_nxt = counter;
    if (clear) begin
      cnt_nxt = '0;
    end else begin
      if (run_en && !tick) div_nxt = div + DIV_W'(1);
      if (tick) cnt_nxt = (counter == 14'(CNT_MAX)) ? '0 : counter + 14'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      timer       <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      counter     <= '0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      ss          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      div       <= div_nxt;
      counter   <= cnt_nxt;
      spi_start <= 1'b0;
      // Updates during a transaction coalesce into the one-deep flag.
      pending   <= pending || upd;

      case (state)
        IDLE: begin
          // An update landing in this very cycle is consumed directly, so
          // the snapshot takes the post-update counter value.
          if (pending || upd) begin
            shadow  <= cnt_nxt;
            pending <= 1'b0;
            timer   <= '0;
            ss      <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (timer == TMR_W'(SS_SETUP - 1)) begin
            spi_start   <= 1'b1;
            spi_tx_data <= {2'b00, shadow[13:8]};
            state       <= SEND_H;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SEND_H: state <= WAIT_H;
        WAIT_H: begin
          if (spi_done) begin
            spi_start   <= 1'b1;
            spi_tx_data <= shadow[7:0];
            state       <= SEND_L;
          end
        end
        SEND_L: state <= WAIT_L;
        WAIT_L: begin
          if (spi_done) begin
`ifdef SPI_CHECKSUM_EN
            spi_start   <= 1'b1;
            spi_tx_data <= {2'b00, shadow[13:8]} ^ shadow[7:0];
            state       <= SEND_C;
`else
            timer <= '0;
            state <= HOLD;
`endif
          end
        end
`ifdef SPI_CHECKSUM_EN
        SEND_C: state <= WAIT_C;
        WAIT_C: begin
          if (spi_done) begin
            timer <= '0;
            state <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (timer == TMR_W'(SS_HOLD - 1)) begin
            ss    <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          ss    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_counter_master_ctrl.sv
// Testbench for spi_counter_master_ctrl. A transaction-level model predicts
// the counter and the timeline of each frame (SS low window, start pulse
// cycles, bytes); the bench itself plays spi_master and returns spi_done at
// model-chosen delays, with occasional stray done pulses where they must be
// ignored. Outputs are compared every cycle on the falling edge.
module tb_spi_counter_master_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_MAX  = 9999;
  localparam int SS_SETUP = 2;
  localparam int SS_HOLD  = 2;
`ifdef SPI_CHECKSUM_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_en = 1'b0;
  logic        clear = 1'b0;
  logic        spi_done = 1'b0;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        ss;
  logic [13:0] counter;
  logic        busy;

  always #5 clk = ~clk;

  spi_counter_master_ctrl #(
    .TICK_DIV (TICK_DIV),
    .CNT_MAX  (CNT_MAX),
    .SS_SETUP (SS_SETUP),
    .SS_HOLD  (SS_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_en      (run_en),
    .clear       (clear),
    .spi_done    (spi_done),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .ss          (ss),
    .counter     (counter),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  int       m_cnt = 0, m_dcnt = 0;
  bit       m_pend = 0, m_act = 0;
  int       m_r = 0, m_end = 0;
  int       m_s[3], m_d[3];
  logic [7:0] m_b[3];
  // expected outputs for the coming cycle
  bit       e_ss = 1, e_start = 0, e_busy = 0;
  logic [7:0] e_tx = '0;
  int       e_cnt = 0;
  int       dly_min = 10, dly_max = 10;
  bit       req_reset = 1, req_run = 0, req_clear = 0;

  // frames as actually sent by the DUT
  logic [7:0]  cap[3];
  int          cap_n = 0;
  logic [23:0] frames[$];

  task automatic summary_and_finish();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      if (errors > 40) summary_and_finish();
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s: got no event expected event within bound (cycle %0d)", name, cyc);
  endtask

  function automatic logic [23:0] frame_word(int v);
    logic [7:0] hi, lo;
    hi = 8'((v >> 8) & 'h3f);
    lo = 8'(v & 'hff);
    if (NBYTES == 3) return {hi, lo, hi ^ lo};
    return {8'h00, hi, lo};
  endfunction

  task automatic compare();
    chk("ss", ss, e_ss);
    chk("busy", busy, e_busy);
    chk("spi_start", spi_start, e_start);
    chk("spi_tx_data", spi_tx_data, e_tx);
    chk("counter", counter, e_cnt);
    if (spi_start === 1'b1) begin
      chk("start_while_ss_high", ss, 0);
      if (cap_n < 3) begin
        cap[cap_n] = spi_tx_data;
        cap_n++;
      end
    end
    if (ss === 1'b1 && cap_n > 0) begin
      logic [23:0] f;
      chk("start_pulses_per_frame", cap_n, NBYTES);
      f = '0;
      for (int i = 0; i < cap_n; i++) f = (f << 8) | 24'(cap[i]);
      frames.push_back(f);
      cap_n = 0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dcnt = 0; m_pend = 0; m_act = 0; m_r = 0;
    e_ss = 1; e_start = 0; e_busy = 0; e_tx = '0; e_cnt = 0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic cycle();
    bit run, clr, dn, ev;
    int t;
    @(negedge clk);
    cyc++;
    compare();
    reset = req_reset;
    run = req_run;
    clr = req_clear;
    dn = 0;
    if (m_act) begin
      for (int i = 0; i < NBYTES; i++) if (m_r == m_s[i] + m_d[i]) dn = 1;
      if (m_r < SS_SETUP || m_r > m_s[NBYTES-1] + m_d[NBYTES-1])
        if ($urandom_range(7, 0) == 0) dn = 1;
    end else if ($urandom_range(7, 0) == 0) dn = 1;
    run_en = run;
    clear = clr;
    spi_done = dn;
    if (req_reset) begin
      model_reset();
      return;
    end
    ev = 0;
    if (clr) begin
      m_cnt = 0; m_dcnt = 0; ev = 1;
    end else if (run) begin
      if (m_dcnt + 1 == TICK_DIV) begin
        m_cnt = (m_cnt == CNT_MAX) ? 0 : m_cnt + 1;
        m_dcnt = 0;
        ev = 1;
      end else m_dcnt++;
    end else m_dcnt = 0;
    if (m_act) begin
      if (ev) m_pend = 1;
      if (m_r == m_end) m_act = 0;
      else m_r++;
    end else if (m_pend || ev) begin
      m_pend = 0; m_act = 1; m_r = 0;
      m_b[0] = 8'((m_cnt >> 8) & 'h3f);
      m_b[1] = 8'(m_cnt & 'hff);
      m_b[2] = m_b[0] ^ m_b[1];
      t = SS_SETUP;
      for (int i = 0; i < NBYTES; i++) begin
        m_s[i] = t;
        m_d[i] = int'($urandom_range(dly_max, dly_min));
        t = t + m_d[i] + 1;
      end
      m_end = t - 1 + SS_HOLD;
    end
    e_ss = !m_act;
    e_busy = m_act;
    e_start = 0;
    if (m_act)
      for (int i = 0; i < NBYTES; i++)
        if (m_r == m_s[i]) begin
          e_start = 1;
          e_tx = m_b[i];
        end
    e_cnt = m_cnt;
  endtask

  task automatic wait_idle();
    int n = 0;
    int k = 0;
    while (n < 2) begin
      cycle();
      k++;
      if (!m_act && !m_pend) n++;
      else n = 0;
      if (k > 3000) begin
        timeout("idle");
        return;
      end
    end
  endtask

  task automatic one_tick();
    req_run = 1;
    repeat (TICK_DIV) cycle();
    req_run = 0;
  endtask

  task automatic advance_to(int target);
    int k = 0;
    req_run = 1;
    while (m_cnt != target - 1) begin
      cycle();
      k++;
      if (k > (target + 2) * TICK_DIV * 2 + 100) begin
        timeout("advance");
        req_run = 0;
        return;
      end
    end
    req_run = 0;
    wait_idle();
    one_tick();
    wait_idle();
  endtask

  logic [23:0] lit_one, lit_1abc, lit_zero;

  initial begin
`ifdef SPI_CHECKSUM_EN
    lit_one = 24'h000101; lit_1abc = 24'h1ABCA6; lit_zero = 24'h000000;
`else
    lit_one = 24'h000001; lit_1abc = 24'h001ABC; lit_zero = 24'h000000;
`endif
    #1 reset = 1'b1;
    repeat (3) cycle();

    // 1: first frame after reset, fixed 10-cycle done latency
    req_reset = 0;
    req_run = 1;
    repeat (4) cycle();
    chk("cnt_before_first_tick", counter, 0);
    cycle();
    chk("first_tick_counter", counter, 1);
    chk("ss_falls_on_first_tick", ss, 0);
    repeat (2) cycle();
    chk("first_start_after_setup", spi_start, 1);
    chk("first_byte", spi_tx_data, 8'h00);
    req_run = 0;
    wait_idle();
    chk("first_frame", frames[0], lit_one);

    // 2: specific values and counter wrap, random latency
    dly_min = 1; dly_max = 12;
    advance_to(6844);
    chk("frame_1abc", frames[frames.size()-1], lit_1abc);
    advance_to(CNT_MAX);
    chk("frame_max", frames[frames.size()-1], frame_word(CNT_MAX));
    one_tick();
    wait_idle();
    chk("wrap_counter", counter, 0);
    chk("wrap_frame", frames[frames.size()-1], lit_zero);

    // 3: slow slave, ticks coalesce
    dly_min = 50; dly_max = 50;
    req_run = 1;
    repeat (400) cycle();
    req_run = 0;
    wait_idle();
    chk("coalesced_latest", frames[frames.size()-1], frame_word(m_cnt));

    // 4a: clear coinciding with a tick
    dly_min = 5; dly_max = 12;
    req_run = 1;
    begin
      int k = 0;
      do begin
        cycle();
        k++;
      end while (!(m_dcnt == TICK_DIV - 1 && m_cnt != 0) && k < 200);
      if (k >= 200) timeout("tick_align");
    end
    req_clear = 1;
    cycle();
    req_clear = 0;
    req_run = 0;
    cycle();
    chk("clear_beats_tick", counter, 0);
    wait_idle();
    chk("clear_tick_frame", frames[frames.size()-1], lit_zero);

    // 4b: clear during WAIT_H does not disturb the frame in flight
    one_tick();
    begin
      int k = 0;
      while (!(m_act && m_r > m_s[0] && m_r <= m_s[0] + m_d[0]) && k < 200) begin
        cycle();
        k++;
      end
      if (k >= 200) timeout("wait_h");
    end
    req_clear = 1;
    cycle();
    req_clear = 0;
    wait_idle();
    chk("inflight_frame", frames[frames.size()-2], lit_one);
    chk("frame_after_clear", frames[frames.size()-1], lit_zero);

    // 5: asynchronous reset in WAIT_L
    dly_min = 8; dly_max = 8;
    req_run = 1;
    repeat (40) cycle();
    begin
      int k = 0;
      while (!(m_act && m_r > m_s[1] && m_r <= m_s[1] + m_d[1]) && k < 200) begin
        cycle();
        k++;
      end
      if (k >= 200) timeout("wait_l");
    end
    chk("counter_nonzero_before_reset", counter != 0, 1);
    reset = 1'b1;
    req_reset = 1;
    #1;
    chk("reset_ss_async", ss, 1);
    chk("reset_busy_async", busy, 0);
    chk("reset_counter_async", counter, 0);
    chk("reset_start_async", spi_start, 0);
    model_reset();
    cap_n = 0;
    repeat (3) cycle();
    req_reset = 0;
    dly_min = 1; dly_max = 12;
    repeat (150) cycle();
    req_run = 0;
    wait_idle();

    summary_and_finish();
  end

endmodule
